// File: rtl/time_set_ctrl.sv
// time_set_ctrl: turns debounced hour/minute set buttons into single-cycle
// increment strobes, with hold-then-auto-repeat, and gates the 1 Hz tick
// while a set is in progress.
module time_set_ctrl #(
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  input  logic i_fast_set_db,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_1hz_stb,
  output logic o_hours_inc_stb,
  output logic o_minutes_inc_stb,
  output logic o_sec_clr_stb,
  output logic o_1hz_stb,
  output logic o_setting
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  typedef enum logic {
    TGT_HOURS   = 1'b0,
    TGT_MINUTES = 1'b1
  } target_e;

  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(HOLD_TICKS);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_TICKS - 1);

  state_e                 state_q, state_d;
  target_e                target_q, target_d;
  logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic                   hrs_q, min_q;
  logic                   rise_h, rise_m;
  logic                   tgt_btn, other_btn, rate_stb;
  logic                   hours_inc_d, minutes_inc_d;
  logic                   hz_d, setting_d;

  // State, edge-detect history and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q           <= ST_IDLE;
      target_q          <= TGT_HOURS;
      hold_cnt_q        <= '0;
      hrs_q             <= 1'b1;
      min_q             <= 1'b1;
      o_hours_inc_stb   <= 1'b0;
      o_minutes_inc_stb <= 1'b0;
      o_sec_clr_stb     <= 1'b0;
      o_1hz_stb         <= 1'b0;
      o_setting         <= 1'b0;
    end else begin
      state_q           <= state_d;
      target_q          <= target_d;
      hold_cnt_q        <= hold_cnt_d;
      hrs_q             <= i_set_hours_db;
      min_q             <= i_set_minutes_db;
      o_hours_inc_stb   <= hours_inc_d;
      o_minutes_inc_stb <= minutes_inc_d;
      o_sec_clr_stb     <= minutes_inc_d;
      o_1hz_stb         <= hz_d;
      o_setting         <= setting_d;
    end
  end

  // Next-state and next-output decode; release beats lockout beats strobes
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    hold_cnt_d    = hold_cnt_q;
    hours_inc_d   = 1'b0;
    minutes_inc_d = 1'b0;

    rise_h    = i_set_hours_db & ~hrs_q;
    rise_m    = i_set_minutes_db & ~min_q;
    tgt_btn   = (target_q == TGT_HOURS) ? i_set_hours_db : i_set_minutes_db;
    other_btn = (target_q == TGT_HOURS) ? i_set_minutes_db : i_set_hours_db;
    rate_stb  = i_fast_set_db ? i_fast_set_stb : i_slow_set_stb;

    case (state_q)
      ST_IDLE: begin
        if ((rise_h | rise_m) & i_set_hours_db & i_set_minutes_db) begin
          state_d = ST_LOCKOUT;
        end else if (rise_h) begin
          target_d    = TGT_HOURS;
          hours_inc_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = ST_HOLD;
        end else if (rise_m) begin
          target_d      = TGT_MINUTES;
          minutes_inc_d = 1'b1;
          hold_cnt_d    = '0;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!tgt_btn) begin
          state_d = ST_IDLE;
        end else if (other_btn) begin
          state_d = ST_LOCKOUT;
        end else if (i_slow_set_stb) begin
          if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
          if (hold_cnt_q >= HOLD_LAST) state_d = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (!tgt_btn) begin
          state_d = ST_IDLE;
        end else if (other_btn) begin
          state_d = ST_LOCKOUT;
        end else if (rate_stb) begin
          hours_inc_d   = (target_q == TGT_HOURS);
          minutes_inc_d = (target_q == TGT_MINUTES);
        end
      end
      ST_LOCKOUT: begin
        if (!i_set_hours_db && !i_set_minutes_db) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    hz_d      = i_1hz_stb & ((state_q == ST_IDLE) | (state_q == ST_LOCKOUT));
    setting_d = (state_d == ST_HOLD) | (state_d == ST_REPEAT);
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed-vector bench for time_set_ctrl.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic i_reset, i_set_hours_db, i_set_minutes_db, i_fast_set_db;
  logic i_slow_set_stb, i_fast_set_stb, i_1hz_stb;
  logic o_hours_inc_stb, o_minutes_inc_stb, o_sec_clr_stb, o_1hz_stb, o_setting;

  int n_checks = 0;
  int n_pass   = 0;
  int hrs_total = 0;
  int min_total = 0;
  int both_cycles = 0;
  int clr_mismatch = 0;

  time_set_ctrl #(.HOLD_TICKS(2), .CNT_WIDTH(3)) dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .i_set_hours_db    (i_set_hours_db),
    .i_set_minutes_db  (i_set_minutes_db),
    .i_fast_set_db     (i_fast_set_db),
    .i_slow_set_stb    (i_slow_set_stb),
    .i_fast_set_stb    (i_fast_set_stb),
    .i_1hz_stb         (i_1hz_stb),
    .o_hours_inc_stb   (o_hours_inc_stb),
    .o_minutes_inc_stb (o_minutes_inc_stb),
    .o_sec_clr_stb     (o_sec_clr_stb),
    .o_1hz_stb         (o_1hz_stb),
    .o_setting         (o_setting)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs then reflect the inputs applied before the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (o_hours_inc_stb) hrs_total++;
    if (o_minutes_inc_stb) min_total++;
    if (o_hours_inc_stb && o_minutes_inc_stb) both_cycles++;
    if (o_sec_clr_stb != o_minutes_inc_stb) clr_mismatch++;
  endtask

  // Single-cycle slow strobe followed by an idle cycle; returns hours/minutes seen
  task automatic slow_pulse(output logic h, output logic m);
    i_slow_set_stb = 1'b1;
    step();
    h = o_hours_inc_stb;
    m = o_minutes_inc_stb;
    i_slow_set_stb = 1'b0;
    step();
  endtask

  logic h, m;

  initial begin
    i_reset = 1'b1; i_set_hours_db = 1'b0; i_set_minutes_db = 1'b0;
    i_fast_set_db = 1'b0; i_slow_set_stb = 1'b0; i_fast_set_stb = 1'b0;
    i_1hz_stb = 1'b1;
    #2;
    step(); step();
    check("rst_hours", o_hours_inc_stb, 0);
    check("rst_min", o_minutes_inc_stb, 0);
    check("rst_clr", o_sec_clr_stb, 0);
    check("rst_1hz", o_1hz_stb, 0);
    check("rst_setting", o_setting, 0);

    // Single short hours press
    i_reset = 1'b0; i_1hz_stb = 1'b0;
    step();
    i_set_hours_db = 1'b1; i_1hz_stb = 1'b1;
    step();
    check("t1_hours_first", o_hours_inc_stb, 1);
    check("t1_1hz_idle", o_1hz_stb, 1);
    check("t1_setting", o_setting, 1);
    i_slow_set_stb = 1'b1;
    step();
    check("t1_hours_held", o_hours_inc_stb, 0);
    check("t1_1hz_gated", o_1hz_stb, 0);
    i_slow_set_stb = 1'b0; i_1hz_stb = 1'b0; i_set_hours_db = 1'b0;
    step();
    check("t1_release_setting", o_setting, 0);
    i_1hz_stb = 1'b1;
    step();
    check("t1_1hz_back", o_1hz_stb, 1);
    check("t1_hours_total", hrs_total, 1);
    i_1hz_stb = 1'b0;

    // Minutes hold: 2 hold ticks then 5 repeats at slow rate
    min_total = 0;
    i_set_minutes_db = 1'b1;
    step();
    check("t2_min_first", o_minutes_inc_stb, 1);
    check("t2_clr_first", o_sec_clr_stb, 1);
    for (int k = 0; k < 7; k++) begin
      slow_pulse(h, m);
      check($sformatf("t2_min_slow%0d", k), m, (k >= 2) ? 1 : 0);
    end
    check("t2_min_total", min_total, 6);
    check("t2_setting", o_setting, 1);
    i_set_minutes_db = 1'b0;
    step();
    check("t2_release", o_setting, 0);

    // Hours repeat, switching to fast rate and back
    i_set_hours_db = 1'b1;
    step();
    check("t3_hours_first", o_hours_inc_stb, 1);
    slow_pulse(h, m);
    slow_pulse(h, m);
    check("t3_enter_repeat", h, 0);
    i_fast_set_db = 1'b1;
    slow_pulse(h, m);
    check("t3_fast_ignores_slow", h, 0);
    i_fast_set_stb = 1'b1;
    step();
    check("t3_fast_stb", o_hours_inc_stb, 1);
    i_fast_set_stb = 1'b0;
    step();
    check("t3_fast_gap", o_hours_inc_stb, 0);
    i_fast_set_db = 1'b0; i_fast_set_stb = 1'b1;
    step();
    check("t3_slow_ignores_fast", o_hours_inc_stb, 0);
    i_fast_set_stb = 1'b0;
    slow_pulse(h, m);
    check("t3_slow_again", h, 1);

    // Release on the same cycle as a rate strobe: no strobe, back to IDLE
    i_set_hours_db = 1'b0; i_slow_set_stb = 1'b1;
    step();
    check("t6_release_no_stb", o_hours_inc_stb, 0);
    check("t6_release_idle", o_setting, 0);
    i_slow_set_stb = 1'b0;
    step();

    // Both buttons together lock out
    hrs_total = 0; min_total = 0;
    i_set_hours_db = 1'b1; i_set_minutes_db = 1'b1;
    step();
    check("t4_lock_setting", o_setting, 0);
    i_set_minutes_db = 1'b0; i_1hz_stb = 1'b1;
    step();
    check("t4_lock_1hz", o_1hz_stb, 1);
    i_1hz_stb = 1'b0;
    slow_pulse(h, m);
    check("t4_lock_hours", hrs_total, 0);
    check("t4_lock_min", min_total, 0);
    check("t4_lock_setting2", o_setting, 0);
    i_set_hours_db = 1'b0;
    step();
    i_set_hours_db = 1'b1;
    step();
    check("t4_after_lock", o_hours_inc_stb, 1);
    i_set_hours_db = 1'b0;
    step();

    // Hold hours through reset mid-REPEAT
    i_set_hours_db = 1'b1;
    step();
    slow_pulse(h, m);
    slow_pulse(h, m);
    slow_pulse(h, m);
    check("t5_repeat_before_rst", h, 1);
    i_reset = 1'b1; i_slow_set_stb = 1'b1;
    step();
    check("t5_rst_drop", o_hours_inc_stb, 0);
    i_reset = 1'b0; i_slow_set_stb = 1'b0;
    hrs_total = 0;
    for (int k = 0; k < 3; k++) slow_pulse(h, m);
    check("t5_held_no_stb", hrs_total, 0);
    check("t5_held_setting", o_setting, 0);
    i_set_hours_db = 1'b0;
    step();
    i_set_hours_db = 1'b1;
    step();
    check("t5_repress", o_hours_inc_stb, 1);
    i_set_hours_db = 1'b0;
    step();

    check("exclusive_strobes", both_cycles, 0);
    check("sec_clr_follows_min", clr_mismatch, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
